// File: rtl/rx_block_fifo.sv
// rx_block_fifo: captures level-held decrypted blocks into a FIFO, releasing the
// upstream holder with a one-cycle strobe after each capture.
module rx_block_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_stb,
    input  logic                    flush,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic [15:0]             blk_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic {IDLE, RELEASE} state_t;
    state_t state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic cap, pop;
    assign full      = level == LW'(DEPTH);
    assign out_valid = level != '0;
    assign out_data  = mem[rd_ptr];
    // RELEASE waits for upstream to drop in_valid so a held block is taken once
    always_comb begin
        cap       = (state == IDLE) && in_valid && !full && !flush;
        pop       = out_valid && out_ready && !flush;
        state_nxt = (state == IDLE) ? (cap ? RELEASE : IDLE) : (in_valid ? RELEASE : IDLE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            in_stb <= 1'b0;
        end else begin
            state  <= state_nxt;
            in_stb <= cap;
        end
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            blk_cnt <= '0;
        end else begin
            if (cap) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(cap) - LW'(pop);
            if (pop && blk_cnt != 16'hFFFF) blk_cnt <= blk_cnt + 16'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (cap) mem[wr_ptr] <= in_data;
    end
endmodule

// File: doc/rx_block_fifo.md
RX_BLOCK_FIFO -- requirements
Module: rx_block_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries, power of two, 2..16.
REQ-002 Parameter DATA_W, default 128, width of one decrypted block.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  DATA_W  decrypted plaintext block from the receive stage (its data output).
REQ-006 in_valid  input  1  level-held by the receive stage until strobed; drops some cycles after in_stb.
REQ-007 in_stb  output  1  one-cycle release pulse to the receive stage (drives its usr_o_stb).
REQ-008 flush  input  1  synchronous clear of stored blocks.
REQ-009 out_data  output  DATA_W  head-of-FIFO block.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_ready  input  1  consumer accepts head when high with out_valid.
REQ-012 level  output  $clog2(DEPTH)+1  entries stored, 0..DEPTH.
REQ-013 full  output  1  level == DEPTH.
REQ-014 blk_cnt  output  16  blocks delivered since reset/flush, saturating.

Function
REQ-015 Capture FSM SHALL have states IDLE and RELEASE.
REQ-016 In IDLE with in_valid=1 and full=0 (full taken before this cycle's pop), block SHALL write in_data at wr_ptr, register in_stb=1 for the next cycle only, and go to RELEASE.
REQ-017 In IDLE with in_valid=1 and full=1, block SHALL neither write nor strobe; input stays held upstream (backpressure, no data loss).
REQ-018 In RELEASE, block SHALL ignore in_valid=1 and return to IDLE on first cycle with in_valid=0; one held block is captured exactly once.
REQ-019 in_stb SHALL be exactly one cycle wide, asserted the cycle after capture; never asserted in two consecutive cycles.
REQ-020 out_valid SHALL equal (level != 0); out_data SHALL be the entry at rd_ptr, combinational from storage.
REQ-021 Pop SHALL occur when out_valid && out_ready; rd_ptr advances, blk_cnt increments and holds at 16'hFFFF.
REQ-022 Simultaneous capture and pop SHALL leave level unchanged; both pointers advance.
REQ-023 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-024 Capture-to-out_valid latency SHALL be 1 cycle (block written on edge N visible at edge N+1); pop effect visible next cycle.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 flush=1 SHALL clear level, pointers, blk_cnt next cycle and take priority over capture and pop in the same cycle.
REQ-027 Flush SHALL NOT alter FSM state or a pending in_stb; a block held upstream in RELEASE stays discarded and is not recaptured.
REQ-028 Storage contents need no reset; only pointers, level and flags are reset.

Reset
REQ-029 On reset SHALL drive: FSM=IDLE, in_stb=0, level=0, full=0, out_valid=0, blk_cnt=0, pointers=0.
REQ-030 Reset mid-handshake (RELEASE or pending in_stb) SHALL abort it: in_stb=0 next cycle; if in_valid still high after reset, the block is captured again as new.
REQ-031 out_data after reset is don't-care while out_valid=0.

Verification
REQ-032 Single block: in_data=128'hA5..A5, in_valid high 3 cycles, out_ready=0 -> one in_stb pulse the cycle after capture, level=1, out_data=A5..A5, no second capture.
REQ-033 Fill: DEPTH=4, present 5 blocks 1..5 -> four in_stb pulses, full=1, block 5 held without strobe; one pop -> block 5 captured, out_data order 1,2,3,4,5.
REQ-034 Concurrent: level=2, capture and pop same cycle -> level stays 2, blk_cnt +1, FIFO order preserved across pointer wrap after 10 blocks.
REQ-035 Flush: level=3, flush=1 with out_ready=1 and in_valid=1 in IDLE -> level=0, blk_cnt=0, no pop counted, no capture that cycle.
REQ-036 Reset in RELEASE with in_valid held high -> in_stb=0, level=0; after reset release, block recaptured with one in_stb.
REQ-037 Saturation: force 65 537 pops -> blk_cnt stays 16'hFFFF.
